srt4: RTL and testbench

SRT4 -- requirements
Module: srt4

---
 rtl/srt4.sv | 114 +++++++++++
 tb/tb_srt4.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/srt4.sv
// srt4: unsigned 8-bit SRT radix-4 divider with a fixed 11-edge latency.
module srt4 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       beginSignal,
  input  logic [7:0] inbus,
  output logic [7:0] outbus,
  output logic       endSignal
);
  typedef enum logic [2:0] {IDLE, LOAD_M, NORM, ITER, CORR, OUT_Q, OUT_R} state_t;
  state_t state, nxt;
  logic [7:0] a, m, low, quo, rem, qa, qf, pc;
  logic [2:0] k, cnt, kk;
  logic signed [10:0] p, pn, qd, d;
  logic signed [11:0] s;
  logic signed [7:0] st, h, t;
  logic signed [2:0] q;
  logic [15:0] ht;
  logic [7:0] dn;
  logic [14:0] an, dsh, p0;
  logic hi, dz, nhi;
  function automatic logic [2:0] lz(input logic [7:0] v);
    lz = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) lz = 3'(7 - i);
  endfunction
  // Normalization; a leading quotient bit of 128 keeps the first residual inside the digit-set bound
  assign kk  = lz(m);
  assign dn  = m << kk;
  assign an  = {7'b0, a} << kk;
  assign dsh = {dn, 7'b0};
  assign nhi = an >= dsh;
  assign p0  = nhi ? an - dsh : an;
  // Digit selection thresholds (in units of 16) indexed by the top bits of the normalized divisor
  always_comb begin
    ht = '0;
    case (m[6:4])
      3'd0: ht = {8'd4, 8'd12};
      3'd1: ht = {8'd5, 8'd14};
      3'd2: ht = {8'd5, 8'd15};
      3'd3: ht = {8'd6, 8'd17};
      3'd4: ht = {8'd6, 8'd18};
      3'd5: ht = {8'd7, 8'd20};
      3'd6: ht = {8'd7, 8'd21};
      3'd7: ht = {8'd8, 8'd23};
      default: ht = '0;
    endcase
  end
  assign h  = ht[15:8];
  assign t  = ht[7:0];
  assign d  = {3'b0, m};
  assign s  = {p[9:0], low[7:6]};
  assign st = s[11:4];
  assign q  = st >= t ? 3'sd2 : st >= h ? 3'sd1 : st >= -h ? 3'sd0 : st >= -t ? -3'sd1 : -3'sd2;
  assign qd = q == 3'sd2 ? d <<< 1 : q == 3'sd1 ? d : q == 3'sd0 ? 11'sd0 : q == -3'sd1 ? -d : -(d <<< 1);
  assign pn = s[10:0] - qd;
  assign qf = qa + {hi, 7'b0} - {7'b0, p[10]};
  assign pc = p[7:0] + (p[10] ? m : 8'd0);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = beginSignal ? LOAD_M : IDLE;
      LOAD_M: nxt = NORM;
      NORM:   nxt = ITER;
      ITER:   nxt = cnt == 3'd1 ? CORR : ITER;
      CORR:   nxt = OUT_Q;
      OUT_Q:  nxt = OUT_R;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) begin
      {a, m, low, quo, rem, qa, k, cnt, hi, dz} <= '0;
      p <= '0;
      outbus <= '0;
      endSignal <= 1'b0;
    end else begin
      outbus <= state == OUT_Q ? quo : state == OUT_R ? rem : 8'd0;
      endSignal <= state == OUT_Q || state == OUT_R;
      case (state)
        IDLE: if (beginSignal) a <= inbus;
        LOAD_M: begin
          m <= inbus;
          dz <= inbus == 8'd0;
        end
        NORM: begin
          cnt <= 3'd4;
          qa <= '0;
          if (!dz) begin
            m <= dn;
            k <= kk;
            hi <= nhi;
            p <= {4'b0, p0[14:8]};
            low <= p0[7:0];
          end
        end
        ITER: begin
          cnt <= cnt - 3'd1;
          if (!dz) begin
            p <= pn;
            low <= low << 2;
            qa <= (qa << 2) + {{5{q[2]}}, q};
          end
        end
        CORR: begin
          quo <= dz ? 8'hFF : qf;
          rem <= dz ? a : pc >> k;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_srt4.sv
// tb_srt4: randomized and directed checks of srt4 against plain integer division.
module tb_srt4;
  logic clk = 1'b0, rst_b = 1'b1, beginSignal = 1'b0;
  logic [7:0] inbus = 8'd0;
  logic [7:0] outbus;
  logic endSignal;
  int checks = 0, errors = 0;

  srt4 dut (.clk(clk), .rst_b(rst_b), .beginSignal(beginSignal), .inbus(inbus),
            .outbus(outbus), .endSignal(endSignal));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // started: E0 already happened (chained); go_next: raise begin with na so E10 starts another run
  task automatic run(input logic [7:0] a, input logic [7:0] m, input bit started,
                     input bit go_next, input logic [7:0] na);
    logic [7:0] eq, er;
    int ends;
    eq = m == 0 ? 8'hFF : a / m;
    er = m == 0 ? a : a % m;
    ends = 0;
    if (!started) begin
      @(negedge clk);
      beginSignal = 1'b1;
      inbus = a;
      @(posedge clk);
      #1;
    end
    inbus = m;
    beginSignal = 1'($urandom);
    ends += int'(endSignal);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      beginSignal = 1'($urandom);
      inbus = 8'($urandom);
      ends += int'(endSignal);
      @(posedge clk);
    end
    #1;
    beginSignal = 1'b0;
    ends += int'(endSignal);
    chk("busy_end", 16'(ends), 16'd0);
    @(posedge clk);
    #1;
    chk($sformatf("q %0d/%0d", a, m), outbus, eq);
    chk("end_q", endSignal, 1);
    @(posedge clk);
    #1;
    chk($sformatf("r %0d/%0d", a, m), outbus, er);
    chk("end_r", endSignal, 1);
    if (go_next) begin
      beginSignal = 1'b1;
      inbus = na;
    end
    @(posedge clk);
    #1;
    chk("out_idle", outbus, 0);
    chk("end_idle", endSignal, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int ends;
    logic [7:0] a, m;
    int r;
    #12;
    chk("rst_out", outbus, 0);
    chk("rst_end", endSignal, 0);
    @(negedge clk);
    rst_b = 1'b0;
    run(216, 21, 0, 0, 0);
    run(255, 1, 0, 0, 0);
    run(255, 255, 0, 0, 0);
    run(100, 7, 0, 0, 0);
    run(5, 200, 0, 0, 0);
    run(37, 0, 0, 0, 0);
    run(0, 9, 0, 0, 0);
    run(200, 3, 0, 1, 77);
    run(77, 5, 1, 0, 0);
    // reset during the iterations: nothing must come out, begin ignored while reset is high
    @(negedge clk);
    beginSignal = 1'b1;
    inbus = 216;
    @(posedge clk);
    #1;
    inbus = 21;
    beginSignal = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_b = 1'b1;
    beginSignal = 1'b1;
    #1;
    chk("abort_out", outbus, 0);
    chk("abort_end", endSignal, 0);
    ends = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      ends += int'(endSignal) + int'(outbus != 0);
    end
    @(negedge clk);
    rst_b = 1'b0;
    beginSignal = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      ends += int'(endSignal) + int'(outbus != 0);
    end
    chk("abort_silent", 16'(ends), 16'd0);
    run(216, 21, 0, 0, 0);
    // reset while the quotient is on the bus must clear it without a clock edge
    @(negedge clk);
    beginSignal = 1'b1;
    inbus = 216;
    @(posedge clk);
    #1;
    inbus = 21;
    beginSignal = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_q", outbus, 10);
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_out", outbus, 0);
    chk("async_end", endSignal, 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("no_rem_after_rst", {7'b0, endSignal, outbus}, 0);
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom);
      m = 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) m = 0;
      else if (r == 1) m = 8'($urandom_range(1, 3));
      else if (r == 2) a = 8'($urandom_range(0, m));
      run(a, m, 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
